// File: rtl/pll_drp_reconfig_ctrl.sv
// PLLE2 run-time reconfiguration sequencer: RMW of the three ClkReg1 DRP registers, then reset/lock with retry.
// Optional lock-loss recovery in IDLE is built when PLL_LOCK_MONITOR_EN is defined.
module pll_drp_reconfig_ctrl #(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int RST_HOLD     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [6:0]  cfg_mult_i,
  input  logic [6:0]  cfg_div0_i,
  input  logic [6:0]  cfg_div1_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        pll_rst_o,
  output logic [6:0]  daddr_o,
  output logic [15:0] di_o,
  input  logic [15:0] do_i,
  output logic        den_o,
  output logic        dwe_o,
  input  logic        drdy_i,
  input  logic        locked_i
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_ASSERT_RST, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
    S_HOLD, S_RELEASE, S_WAIT_LOCK, S_DONE, S_ERR
  } state_t;

  state_t             state_q;
  logic [6:0]         mult_q, div0_q, div1_q;
  logic [1:0]         idx_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RTY_W-1:0]   retry_q;
  logic               lock_meta_q, lock_s_q;
  logic               cfg_ready_q, busy_q, done_q, err_q, pll_rst_q, den_q, dwe_q;
  logic [6:0]         daddr_q;
  logic [15:0]        di_q;
`ifdef PLL_LOCK_MONITOR_EN
  logic               lock_good_q;
  logic [1:0]         loss_cnt_q;
`endif

  logic [6:0] n_sel;
  logic [5:0] hi_cnt, lo_cnt;
  logic       cfg_bad;

  function automatic logic [6:0] addr_of(input logic [1:0] idx);
    case (idx)
      2'd0:    addr_of = 7'h08;
      2'd1:    addr_of = 7'h0A;
      default: addr_of = 7'h14;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [6:0] v);
    out_of_range = (v < 7'd2) || (v > 7'd64);
  endfunction

  always_comb begin
    case (idx_q)
      2'd0:    n_sel = div0_q;
      2'd1:    n_sel = div1_q;
      default: n_sel = mult_q;
    endcase
  end

  // low = N - high never exceeds 32, so modulo-64 subtraction is exact (N=64 -> 32/32)
  assign hi_cnt  = n_sel[6:1];
  assign lo_cnt  = n_sel[5:0] - hi_cnt;
  assign cfg_bad = out_of_range(mult_q) || out_of_range(div0_q) || out_of_range(div1_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mult_q      <= '0;
      div0_q      <= '0;
      div1_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      pll_rst_q   <= 1'b1;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
`ifdef PLL_LOCK_MONITOR_EN
      lock_good_q <= 1'b0;
      loss_cnt_q  <= '0;
`endif
    end else begin
      lock_meta_q <= locked_i;
      lock_s_q    <= lock_meta_q;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid_i) begin
            mult_q      <= cfg_mult_i;
            div0_q      <= cfg_div0_i;
            div1_q      <= cfg_div1_i;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            retry_q     <= '0;
            state_q     <= S_CHECK;
`ifdef PLL_LOCK_MONITOR_EN
            lock_good_q <= 1'b0;
            loss_cnt_q  <= '0;
          end else if (lock_good_q && !lock_s_q) begin
            // fourth consecutive unlocked cycle: re-run the reset/lock tail only
            if (loss_cnt_q == 2'd3) begin
              loss_cnt_q  <= '0;
              lock_good_q <= 1'b0;
              cfg_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              pll_rst_q   <= 1'b1;
              retry_q     <= '0;
              cnt_q       <= CNT_W'(RST_HOLD - 1);
              state_q     <= S_HOLD;
            end else begin
              loss_cnt_q <= loss_cnt_q + 2'd1;
            end
          end else begin
            loss_cnt_q <= '0;
`endif
          end
        end
        S_CHECK: begin
          if (cfg_bad) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            pll_rst_q <= 1'b1;
            idx_q     <= '0;
            state_q   <= S_ASSERT_RST;
          end
        end
        S_ASSERT_RST: begin
          den_q   <= 1'b1;
          daddr_q <= addr_of(2'd0);
          state_q <= S_RD;
        end
        S_RD: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (drdy_i) begin
            di_q    <= (do_i & 16'hF000) | {4'h0, hi_cnt, lo_cnt};
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            state_q <= S_WR;
          end
        end
        S_WR: state_q <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (drdy_i) begin
            if (idx_q == 2'd2) begin
              cnt_q   <= CNT_W'(RST_HOLD - 1);
              state_q <= S_HOLD;
            end else begin
              idx_q   <= idx_q + 2'd1;
              den_q   <= 1'b1;
              daddr_q <= addr_of(idx_q + 2'd1);
              state_q <= S_RD;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            pll_rst_q <= 1'b0;
            state_q   <= S_RELEASE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RELEASE: begin
          cnt_q   <= CNT_W'(LOCK_TIMEOUT - 1);
          state_q <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
`ifdef PLL_LOCK_MONITOR_EN
            lock_good_q <= 1'b1;
`endif
          end else if (cnt_q == '0) begin
            pll_rst_q <= 1'b1;
            if (retry_q < RTY_W'(MAX_RETRY)) begin
              retry_q <= retry_q + 1'b1;
              cnt_q   <= CNT_W'(RST_HOLD - 1);
              state_q <= S_HOLD;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_ERR;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          cfg_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_ERR: begin
          cfg_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready_o = cfg_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign pll_rst_o   = pll_rst_q;
  assign den_o       = den_q;
  assign dwe_o       = dwe_q;
  assign daddr_o     = daddr_q;
  assign di_o        = di_q;

endmodule

// File: tb/tb_pll_drp_reconfig_ctrl.sv
// Bench for pll_drp_reconfig_ctrl: DRP responder model plus a scoreboard of expected DRP accesses.
module tb_pll_drp_reconfig_ctrl;
  localparam int LT = 100;
  localparam int MR = 3;
  localparam int RH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [6:0]  cfg_mult, cfg_div0, cfg_div1;
  logic        busy, done, err, pll_rst;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] do_v;
  logic        den, dwe, drdy, locked;

  always #5 clk = ~clk;

  pll_drp_reconfig_ctrl #(.LOCK_TIMEOUT(LT), .MAX_RETRY(MR), .RST_HOLD(RH)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_mult_i(cfg_mult), .cfg_div0_i(cfg_div0), .cfg_div1_i(cfg_div1),
    .busy_o(busy), .done_o(done), .err_o(err), .pll_rst_o(pll_rst),
    .daddr_o(daddr), .di_o(di), .do_i(do_v), .den_o(den), .dwe_o(dwe),
    .drdy_i(drdy), .locked_i(locked)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } txn_t;
  txn_t exp_q[$];

  // mult=63 div0=2 div1=4 with do=0x1000: 2->1/1, 4->2/2, 63->31/32
  task automatic push_cfg();
    exp_q.push_back('{1'b0, 7'h08, 16'h0000});
    exp_q.push_back('{1'b1, 7'h08, 16'h1041});
    exp_q.push_back('{1'b0, 7'h0A, 16'h0000});
    exp_q.push_back('{1'b1, 7'h0A, 16'h1082});
    exp_q.push_back('{1'b0, 7'h14, 16'h0000});
    exp_q.push_back('{1'b1, 7'h14, 16'h17E0});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: pops the scoreboard on every DRP access and checks handshake rules
  int   den_total = 0;
  int   fall_cnt  = 0;
  logic outstanding = 1'b0;
  logic prev_den = 1'b0;
  logic prev_prst = 1'b1;
  initial forever begin
    txn_t t;
    @(negedge clk);
    if (rst) begin
      outstanding = 1'b0;
    end else begin
      if (dwe) chk("dwe_with_den", den, 1);
      if (den) begin
        chk("den_single_cycle", prev_den, 0);
        chk("den_no_overlap", outstanding, 0);
        chk("den_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          t = exp_q.pop_front();
          chk("drp_we", dwe, t.we);
          chk("drp_addr", daddr, t.addr);
          if (t.we) chk("drp_data", di, t.data);
        end
        outstanding = 1'b1;
        den_total++;
      end
      if (drdy) outstanding = 1'b0;
    end
    if (prev_prst && !pll_rst) fall_cnt++;
    prev_prst = pll_rst;
    prev_den  = den;
  end

  // DRP responder: drdy one pulse, drdy_delay cycles after each den
  int drdy_delay = 1;
  int den_seen   = 0;
  int pend       = 0;
  int last_drdy_cyc = 0;
  initial begin
    drdy = 1'b0;
    do_v = 16'h1000;
    forever begin
      @(posedge clk);
      #1;
      drdy = 1'b0;
      if (rst) begin
        pend     = 0;
        den_seen = den_total;
      end else begin
        if (den_total != den_seen) begin
          den_seen = den_total;
          pend     = drdy_delay;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            drdy = 1'b1;
            last_drdy_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic request(input string nm, input logic [6:0] m, input logic [6:0] d0, input logic [6:0] d1);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready_before"}, cfg_ready, 1);
    cfg_mult  = m;
    cfg_div0  = d0;
    cfg_div1  = d1;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk({nm, "_ready_drop"}, cfg_ready, 0);
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_err_cleared"}, err, 0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, done, 1);
  endtask

  task automatic wait_prst(input string nm, input logic lvl, input int budget, output int at);
    int n = 0;
    while (pll_rst !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    at = cyc;
    chk(nm, pll_rst, lvl);
  endtask

  initial begin
    int at, rise_at, base, den_base;
    rst = 1'b1; cfg_valid = 1'b0; cfg_mult = '0; cfg_div0 = '0; cfg_div1 = '0; locked = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_den_dwe", {den, dwe}, 0);
    chk("rst_daddr_di", {daddr, di}, 0);
    rst = 1'b0;
    @(negedge clk);

    // nominal reconfiguration
    drdy_delay = 1;
    push_cfg();
    request("t1", 7'd63, 7'd2, 7'd4);
    wait_prst("t1_release", 1'b0, 300, at);
    chk("t1_hold_timing", at, last_drdy_cyc + 1 + RH);
    chk("t1_queue_drained", exp_q.size(), 0);
    locked = 1'b1;
    wait_done("t1_done", 20);
    chk("t1_err", err, 0);
    chk("t1_busy_in_done", busy, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_ready_back", cfg_ready, 1);
    chk("t1_pll_running", pll_rst, 0);

    // illegal divider
    den_base = den_total;
    request("t2", 7'd10, 7'd3, 7'd1);
    @(negedge clk);
    chk("t2_err", err, 1);
    chk("t2_pll_rst_kept", pll_rst, 0);
    @(negedge clk);
    chk("t2_busy_idle", busy, 0);
    chk("t2_err_sticky", err, 1);
    repeat (3) @(negedge clk);
    chk("t2_no_den", den_total - den_base, 0);

    // lock never arrives: first window plus MR retries
    locked = 1'b0;
    push_cfg();
    base = fall_cnt;
    request("t3", 7'd63, 7'd2, 7'd4);
    begin
      int n = 0;
      while (err !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t3_err", err, 1);
    chk("t3_pll_rst", pll_rst, 1);
    chk("t3_busy", busy, 0);
    chk("t3_windows", fall_cnt - base, MR + 1);
    chk("t3_queue_drained", exp_q.size(), 0);

    // slow DRP
    drdy_delay = 7;
    locked = 1'b1;
    push_cfg();
    request("t4", 7'd63, 7'd2, 7'd4);
    wait_prst("t4_release", 1'b0, 400, at);
    chk("t4_hold_timing", at, last_drdy_cyc + 1 + RH);
    wait_done("t4_done", 20);
    chk("t4_err", err, 0);
    chk("t4_queue_drained", exp_q.size(), 0);

    // reset during the second write's wait, then a clean rerun
    push_cfg();
    request("t5", 7'd63, 7'd2, 7'd4);
    begin
      int n = 0;
      while (!(den && dwe && daddr == 7'h0A) && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t5_reach_wr1", den && dwe && daddr == 7'h0A, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_ready", cfg_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pll_rst", pll_rst, 1);
    chk("t5_rst_drp", {den, dwe, daddr, di}, 0);
    chk("t5_rst_done_err", {done, err}, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_cfg();
    request("t5b", 7'd63, 7'd2, 7'd4);
    wait_done("t5_done", 400);
    chk("t5_err", err, 0);
    chk("t5_queue_drained", exp_q.size(), 0);

`ifdef PLL_LOCK_MONITOR_EN
    // lock loss recovery without DRP traffic
    repeat (3) @(negedge clk);
    den_base = den_total;
    locked = 1'b0;
    repeat (5) @(negedge clk);
    locked = 1'b1;
    wait_prst("t6_rst_rise", 1'b1, 40, rise_at);
    wait_prst("t6_rst_fall", 1'b0, 60, at);
    chk("t6_rst_width", at - rise_at, RH);
    wait_done("t6_done", 40);
    chk("t6_no_den", den_total - den_base, 0);
`else
    // lock loss is ignored
    repeat (3) @(negedge clk);
    locked = 1'b0;
    repeat (12) @(negedge clk);
    chk("t6_pll_rst_low", pll_rst, 0);
    chk("t6_idle", {cfg_ready, busy}, 2'b10);
    locked = 1'b1;
    rise_at = 0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
